// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and types.
// Arbiter state encoding, the NOP instruction and base opcodes.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OP_OP     = 7'b011_0011;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: loadable down-counter with expiry flag.
// Expired while the count sits at zero; it never wraps.
module mem_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);
    import pipe_pkg::*;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM access.
// Data beats fetch; bus outputs are registered; a timeout returns NOP or zero.
module mem_port_arbiter #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(pipe_pkg::NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_done,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_be,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  bus_err
);
    import pipe_pkg::*;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_is_data;
    logic       r_drop;
    logic       w_dm_req;
    logic       w_start;
    logic       w_busy;
    logic       w_ack;
    logic       w_expired;
    logic       w_timeout;

    assign w_dm_req  = dm_rd | dm_wr;
    assign w_start   = (r_state == ST_IDLE) & (w_dm_req | if_req);
    assign w_busy    = (r_state == ST_FETCH) | (r_state == ST_DATA);
    assign w_ack     = w_busy & bus_ack;
    assign w_timeout = w_busy & ~bus_ack & w_expired;

    // Loaded with TIMEOUT-1 so bus_req stays up for exactly TIMEOUT cycles
    mem_timeout_ctr #(
        .W(CNT_W)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_start),
        .i_load_val(CNT_LOAD),
        .i_en      (w_busy & ~bus_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_dm_req) begin
                    w_next = ST_DATA;
                end else if (if_req) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (bus_ack || w_expired) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        if_valid = 1'b0;
        dm_done  = 1'b0;
        if (r_state == ST_RESP) begin
            dm_done  = r_is_data;
            if_valid = ~r_is_data & ~r_drop & ~if_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
            r_drop    <= 1'b0;
            r_is_data <= 1'b0;
        end else begin
            if (w_start) begin
                bus_req   <= 1'b1;
                r_is_data <= w_dm_req;
                if (w_dm_req) begin
                    bus_we    <= dm_wr;
                    bus_addr  <= dm_addr;
                    bus_wdata <= dm_wdata;
                    bus_be    <= dm_wr ? dm_be : '1;
                end else begin
                    bus_we    <= 1'b0;
                    bus_addr  <= if_addr;
                    bus_wdata <= '0;
                    bus_be    <= '1;
                end
            end
            if (w_ack) begin
                bus_req <= 1'b0;
                if (!r_is_data) begin
                    if_rdata <= bus_rdata;
                end else if (!bus_we) begin
                    dm_rdata <= bus_rdata;
                end
            end else if (w_timeout) begin
                bus_req <= 1'b0;
                bus_err <= 1'b1;
                if (!r_is_data) begin
                    if_rdata <= NOP_INSTR;
                end else if (!bus_we) begin
                    dm_rdata <= '0;
                end
            end
            // A fetch in flight cannot be aborted; only its response is dropped
            if ((r_state == ST_FETCH) && if_flush) begin
                r_drop <= 1'b1;
            end else if (r_state == ST_RESP) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign stall_mem = w_dm_req & ~dm_done;
    assign stall_if  = (if_req & ~if_valid) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against
// a memory model and a transaction-level reference of the arbiter.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_be   (bus_be),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } txn_t;

    int errors = 0;
    int checks = 0;
    int ack_lat = 0;
    int req_age = 0;
    logic [31:0] phys [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] exp_dm_rdata = '0;
    logic s_bus_req, s_if_req, s_dm_req, s_if_valid, s_dm_done;
    logic s_stall_if, s_stall_mem;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys.exists(a)) return phys[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (refm.exists(a)) return refm[a];
        return init_word(a);
    endfunction

    // One clock: memory device responds, outputs are sampled, requesters
    // drop their request on the completion pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        if (bus_req) begin
            req_age++;
            if (ack_lat > 0 && req_age == ack_lat) begin
                bus_ack = 1'b1;
                if (bus_we) begin
                    phys[bus_addr] = merge(phys_rd(bus_addr), bus_wdata, bus_be);
                    bus_rdata = $urandom;
                end else begin
                    bus_rdata = phys_rd(bus_addr);
                end
            end
        end else begin
            req_age = 0;
        end
        #1;
        s_bus_req   = bus_req;
        s_if_req    = if_req;
        s_dm_req    = dm_rd | dm_wr;
        s_if_valid  = if_valid;
        s_dm_done   = dm_done;
        s_stall_if  = stall_if;
        s_stall_mem = stall_mem;
        if (if_valid) if_req = 1'b0;
        if (dm_done) begin
            dm_rd = 1'b0;
            dm_wr = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ack_lat = 0;
        repeat (3) tick();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b a=%h wd=%h be=%h want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_be);
        end
        checks++;
        if ({if_rdata, dm_rdata, if_valid, dm_done} !== '0) begin
            errors++;
            $display("FAIL reset_result: got ir=%h dr=%h v=%b d=%b want 0",
                     if_rdata, dm_rdata, if_valid, dm_done);
        end
        checks++;
        if ({bus_err, stall_if, stall_mem} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got err=%b sif=%b smem=%b want 000",
                     bus_err, stall_if, stall_mem);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int nreq, nval, bad;
        nreq = 0; nval = 0; bad = 0;
        phys[32'h40] = 32'h0050_0093;
        refm[32'h40] = 32'h0050_0093;
        ack_lat = 2;
        if_addr = 32'h40;
        if_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_bus_req) begin
                nreq++;
                if (bus_addr !== 32'h40 || bus_we !== 1'b0 || bus_be !== 4'hF) bad++;
            end
            if (s_if_req && (s_stall_if !== !s_if_valid)) bad++;
            if (s_if_valid) begin
                nval++;
                checks++;
                if (if_rdata !== ref_rd(32'h40)) begin
                    errors++;
                    $display("FAIL fetch_rdata: got %h want %h", if_rdata, ref_rd(32'h40));
                end
            end
        end
        checks++;
        if (nreq != 2) begin
            errors++;
            $display("FAIL fetch_req_cycles: got %0d want 2", nreq);
        end
        checks++;
        if (nval != 1) begin
            errors++;
            $display("FAIL fetch_valid_pulses: got %0d want 1", nval);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fetch_bus_or_stall: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_simul();
        logic [31:0] order[$];
        int nd, nv, bad, t_done, t_fetch;
        nd = 0; nv = 0; bad = 0; t_done = -100; t_fetch = -1;
        ack_lat = 1;
        if_addr = 32'h44;
        dm_addr = 32'h1000;
        if_req = 1'b1;
        dm_rd = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (s_bus_req && req_age == 1) begin
                order.push_back(bus_addr);
                if (bus_addr == 32'h44) t_fetch = c;
            end
            if (s_dm_req && !s_stall_if) bad++;
            if (s_dm_done) begin
                nd++;
                t_done = c;
                checks++;
                if (dm_rdata !== ref_rd(32'h1000)) begin
                    errors++;
                    $display("FAIL simul_load: got %h want %h", dm_rdata, ref_rd(32'h1000));
                end
                exp_dm_rdata = ref_rd(32'h1000);
            end
            if (s_if_valid) begin
                nv++;
                checks++;
                if (if_rdata !== ref_rd(32'h44)) begin
                    errors++;
                    $display("FAIL simul_fetch: got %h want %h", if_rdata, ref_rd(32'h44));
                end
            end
        end
        checks++;
        if (order.size() != 2 || order[0] !== 32'h1000 || order[1] !== 32'h44) begin
            errors++;
            $display("FAIL simul_order: got %0d txns first=%h want 1000 then 44",
                     order.size(), (order.size() > 0) ? order[0] : 32'hX);
        end
        checks++;
        if (nd != 1 || nv != 1) begin
            errors++;
            $display("FAIL simul_pulses: got done=%0d valid=%0d want 1/1", nd, nv);
        end
        checks++;
        if (t_fetch - t_done != 2) begin
            errors++;
            $display("FAIL simul_gap: got %0d cycles from done to fetch want 2", t_fetch - t_done);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL simul_stall_if: got %0d unstalled cycles want 0", bad);
        end
    endtask

    task automatic test_store();
        int nreq, nd, bad;
        logic [31:0] want;
        nreq = 0; nd = 0; bad = 0;
        ack_lat = 2;
        dm_addr = 32'h2004;
        dm_wdata = 32'hDEAD_BEEF;
        dm_be = 4'b0011;
        dm_wr = 1'b1;
        refm[32'h2004] = merge(ref_rd(32'h2004), 32'hDEAD_BEEF, 4'b0011);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_bus_req) begin
                nreq++;
                if (bus_we !== 1'b1 || bus_addr !== 32'h2004 ||
                    bus_wdata !== 32'hDEAD_BEEF || bus_be !== 4'b0011) bad++;
            end
            if (s_dm_done) nd++;
        end
        checks++;
        if (nreq != 2 || bad != 0) begin
            errors++;
            $display("FAIL store_bus: got %0d req cycles %0d bad want 2/0", nreq, bad);
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL store_done: got %0d pulses want 1", nd);
        end
        checks++;
        if (dm_rdata !== exp_dm_rdata) begin
            errors++;
            $display("FAIL store_rdata_kept: got %h want %h", dm_rdata, exp_dm_rdata);
        end
        want = ref_rd(32'h2004);
        ack_lat = 1;
        dm_rd = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (dm_rdata !== want) begin
            errors++;
            $display("FAIL store_readback: got %h want %h", dm_rdata, want);
        end
        exp_dm_rdata = want;
    endtask

    task automatic test_flush();
        int nv, ack48;
        nv = 0; ack48 = 0;
        ack_lat = 3;
        if_addr = 32'h48;
        if_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus_ack && bus_addr == 32'h48) ack48++;
            if (s_if_valid) begin
                nv++;
                checks++;
                if (if_rdata !== ref_rd(32'h80)) begin
                    errors++;
                    $display("FAIL flush_next_fetch: got %h want %h", if_rdata, ref_rd(32'h80));
                end
            end
            if (c == 0) begin
                if_flush = 1'b1;
                if_addr = 32'h80;
            end
            if (c == 1) if_flush = 1'b0;
        end
        checks++;
        if (ack48 != 1) begin
            errors++;
            $display("FAIL flush_bus_complete: got %0d acks for 48 want 1", ack48);
        end
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL flush_valid_count: got %0d want 1", nv);
        end
    endtask

    task automatic test_ack_at_limit();
        int nreq, nv;
        nreq = 0; nv = 0;
        ack_lat = TO;
        if_addr = 32'h60;
        if_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_bus_req) nreq++;
            if (s_if_valid) begin
                nv++;
                checks++;
                if (if_rdata !== ref_rd(32'h60)) begin
                    errors++;
                    $display("FAIL limit_rdata: got %h want %h", if_rdata, ref_rd(32'h60));
                end
            end
        end
        checks++;
        if (nreq != TO || nv != 1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL limit_ack: got req=%0d valid=%0d err=%b want %0d/1/0",
                     nreq, nv, bus_err, TO);
        end
    endtask

    task automatic test_timeout();
        int nreq, nv, nd;
        nreq = 0; nv = 0; nd = 0;
        ack_lat = 0;
        if_addr = 32'h50;
        if_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_bus_req) nreq++;
            if (s_if_valid) begin
                nv++;
                checks++;
                if (if_rdata !== 32'h0000_0013) begin
                    errors++;
                    $display("FAIL timeout_nop: got %h want 00000013", if_rdata);
                end
            end
        end
        checks++;
        if (nreq != TO || nv != 1) begin
            errors++;
            $display("FAIL timeout_fetch: got req=%0d valid=%0d want %0d/1", nreq, nv, TO);
        end
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_set: got %b want 1", bus_err);
        end
        dm_addr = 32'h3000;
        dm_rd = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_dm_done) nd++;
        end
        exp_dm_rdata = '0;
        checks++;
        if (nd != 1 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_load: got done=%0d rdata=%h want 1/0", nd, dm_rdata);
        end
        ack_lat = 1;
        if_addr = 32'h54;
        if_req = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (bus_err !== 1'b1 || if_rdata !== ref_rd(32'h54)) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b rdata=%h want 1/%h",
                     bus_err, if_rdata, ref_rd(32'h54));
        end
    endtask

    task automatic test_reset_mid();
        int nd, nreq, t_valid;
        nd = 0; nreq = 0; t_valid = -1;
        ack_lat = 0;
        dm_addr = 32'h1000;
        dm_rd = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus_req !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_edge: got req=%b err=%b want 0/0", bus_req, bus_err);
        end
        rst = 1'b0;
        dm_rd = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_dm_done) nd++;
            if (s_bus_req) nreq++;
        end
        exp_dm_rdata = '0;
        checks++;
        if (nd != 0 || nreq != 0 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_ack_ignored: got done=%0d req=%0d rdata=%h want 0/0/0",
                     nd, nreq, dm_rdata);
        end
        ack_lat = 1;
        if_addr = 32'h70;
        if_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (s_if_valid && t_valid < 0) t_valid = c;
        end
        checks++;
        if (t_valid != 2) begin
            errors++;
            $display("FAIL rstmid_min_latency: got valid at cycle %0d want 2", t_valid);
        end
    endtask

    task automatic test_random();
        txn_t q[$];
        txn_t t, g;
        logic has_f, has_d, w;
        logic [31:0] da, fa, wd, exp_load, exp_fetch;
        logic [3:0] be;
        int p, k, c;
        for (int it = 0; it < 40; it++) begin
            p = $urandom_range(0, 3);
            ack_lat = $urandom_range(1, 3);
            has_f = (p == 0) || (p == 3);
            has_d = (p != 0);
            k = (p == 1) ? 0 : (p == 2) ? 1 : $urandom_range(0, 2);
            w = (k != 0);
            da = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            fa = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            exp_load = '0;
            exp_fetch = '0;
            q.delete();
            if (has_d) begin
                t.a = da; t.we = w; t.be = w ? be : 4'hF; t.wd = wd;
                q.push_back(t);
                if (w) refm[da] = merge(ref_rd(da), wd, be);
                else exp_load = ref_rd(da);
                dm_addr = da; dm_wdata = wd; dm_be = be;
                dm_rd = (k != 1);
                dm_wr = w;
            end
            if (has_f) begin
                t.a = fa; t.we = 1'b0; t.be = 4'hF; t.wd = '0;
                q.push_back(t);
                exp_fetch = ref_rd(fa);
                if_addr = fa;
                if_req = 1'b1;
            end
            c = 0;
            while ((if_req || dm_rd || dm_wr) && c < 30) begin
                tick();
                c++;
                checks++;
                if (s_stall_mem !== (s_dm_req && !s_dm_done) ||
                    s_stall_if !== ((s_if_req && !s_if_valid) || (s_dm_req && !s_dm_done))) begin
                    errors++;
                    $display("FAIL rand_stall it%0d: got if=%b mem=%b", it, s_stall_if, s_stall_mem);
                end
                if (s_bus_req && req_age == 1) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra_txn it%0d: got addr %h want none", it, bus_addr);
                    end else begin
                        g = q.pop_front();
                        if (bus_addr !== g.a || bus_we !== g.we || bus_be !== g.be ||
                            (g.we && bus_wdata !== g.wd)) begin
                            errors++;
                            $display("FAIL rand_txn it%0d: got a=%h we=%b be=%h wd=%h want a=%h we=%b be=%h wd=%h",
                                     it, bus_addr, bus_we, bus_be, bus_wdata, g.a, g.we, g.be, g.wd);
                        end
                    end
                end
                if (s_dm_done) begin
                    if (!w) exp_dm_rdata = exp_load;
                    checks++;
                    if (dm_rdata !== exp_dm_rdata) begin
                        errors++;
                        $display("FAIL rand_dm_rdata it%0d: got %h want %h", it, dm_rdata, exp_dm_rdata);
                    end
                end
                if (s_if_valid) begin
                    checks++;
                    if (if_rdata !== exp_fetch) begin
                        errors++;
                        $display("FAIL rand_if_rdata it%0d: got %h want %h", it, if_rdata, exp_fetch);
                    end
                end
            end
            checks++;
            if (if_req || dm_rd || dm_wr || q.size() != 0) begin
                errors++;
                $display("FAIL rand_complete it%0d: got %0d txns left after %0d cycles want 0",
                         it, q.size(), c);
                if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
                repeat (TO + 3) tick();
            end
            tick();
        end
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_no_err: got %b want 0", bus_err);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simul();
        test_store();
        test_flush();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
